// File: rtl/pwm_pkg.sv
// Shared constants and types for the PWM generator.
// Dead-time insertion is built only when PWM_DEADTIME_EN is defined.
package pwm_pkg;
  localparam int PWM_WIDTH_DEF = 8;
  localparam int PRESCALE_DEF  = 1;
  localparam int DEADTIME_DEF  = 2;

  typedef enum logic [1:0] {LO, HI, DEAD_TO_HI, DEAD_TO_LO} dt_state_e;

  // Counter width for values 0..n-1, never below one bit.
  function automatic int cw(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/pwm_if.sv
// Control/output bundle of the PWM generator: en/duty in, pwm/pwm_n/period_start out.
interface pwm_if import pwm_pkg::*; #(parameter int WIDTH = PWM_WIDTH_DEF);
  logic             en;
  logic [WIDTH-1:0] duty;
  logic             pwm;
  logic             pwm_n;
  logic             period_start;

  modport master (output en, duty, input pwm, pwm_n, period_start);
  modport slave  (input en, duty, output pwm, pwm_n, period_start);
endinterface

// File: rtl/pwm_deadtime.sv
// Dead-time inserter: turns the raw compare level into non-overlapping pwm/pwm_n.
// Used by pwm_gen only when PWM_DEADTIME_EN is defined.
module pwm_deadtime import pwm_pkg::*; #(
  parameter int DEADTIME = DEADTIME_DEF
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  input  logic raw,
  output logic pwm,
  output logic pwm_n
);
  localparam int CW = cw(DEADTIME + 1);

  dt_state_e     state, state_nxt;
  logic [CW-1:0] cnt, cnt_nxt;

  // Stopped/reset parks in a full dead window so the first drive after enable also waits.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= DEAD_TO_LO;
      cnt   <= CW'(DEADTIME);
      pwm   <= 1'b0;
      pwm_n <= 1'b0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      pwm   <= (state_nxt == HI);
      pwm_n <= (state_nxt == LO);
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    if (!en) begin
      state_nxt = DEAD_TO_LO;
      cnt_nxt   = CW'(DEADTIME);
    end else begin
      case (state)
        HI: if (!raw) begin
          state_nxt = DEAD_TO_LO;
          cnt_nxt   = CW'(DEADTIME - 1);
        end
        LO: if (raw) begin
          state_nxt = DEAD_TO_HI;
          cnt_nxt   = CW'(DEADTIME - 1);
        end
        DEAD_TO_HI: begin
          if (!raw) begin
            state_nxt = DEAD_TO_LO;
            cnt_nxt   = CW'(DEADTIME - 1);
          end else if (cnt == '0) state_nxt = HI;
          else                     cnt_nxt   = cnt - 1'b1;
        end
        DEAD_TO_LO: begin
          if (raw) begin
            state_nxt = DEAD_TO_HI;
            cnt_nxt   = CW'(DEADTIME - 1);
          end else if (cnt == '0) state_nxt = LO;
          else                     cnt_nxt   = cnt - 1'b1;
        end
        default: begin
          state_nxt = DEAD_TO_LO;
          cnt_nxt   = CW'(DEADTIME);
        end
      endcase
    end
  end
endmodule

// File: rtl/pwm_gen.sv
// Registered PWM generator: prescaler, period counter, double-buffered duty, compare.
// Define PWM_DEADTIME_EN to insert DEADTIME clk of both-low around every output edge.
module pwm_gen import pwm_pkg::*; #(
  parameter int WIDTH    = PWM_WIDTH_DEF,
  parameter int PRESCALE = PRESCALE_DEF,
  parameter int DEADTIME = DEADTIME_DEF
) (
  input logic clk,
  input logic rst_n,
  pwm_if.slave bus
);
  localparam logic [WIDTH-1:0] CTR_MAX = WIDTH'((2**WIDTH) - 1);
  localparam int               PW      = cw(PRESCALE);

  if (PRESCALE < 1 || DEADTIME < 1) begin : g_bad_param
    $error("pwm_gen: PRESCALE and DEADTIME must be >= 1");
  end

  logic [PW-1:0]    presc_cnt;
  logic [WIDTH-1:0] ctr, duty_shadow;
  logic             tick, wrap, raw;
  logic             pwm_q, pwm_n_q, ps_q;

  assign tick = bus.en && (presc_cnt == PW'(PRESCALE - 1));
  assign wrap = tick && (ctr == CTR_MAX);
  assign raw  = bus.en && (ctr < duty_shadow);

  // While stopped the shadow tracks duty, so a restart runs with the value held at en rise.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      presc_cnt   <= '0;
      ctr         <= '0;
      duty_shadow <= '0;
      ps_q        <= 1'b0;
    end else if (!bus.en) begin
      presc_cnt   <= '0;
      ctr         <= '0;
      duty_shadow <= bus.duty;
      ps_q        <= 1'b0;
    end else begin
      presc_cnt <= tick ? '0 : presc_cnt + 1'b1;
      if (tick) ctr <= ctr + 1'b1;
      if (wrap) duty_shadow <= bus.duty;
      ps_q <= wrap;
    end
  end

`ifdef PWM_DEADTIME_EN
  pwm_deadtime #(.DEADTIME(DEADTIME)) u_deadtime (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (bus.en),
    .raw   (raw),
    .pwm   (pwm_q),
    .pwm_n (pwm_n_q)
  );
`else
  logic en_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pwm_q <= 1'b0;
      en_q  <= 1'b0;
    end else begin
      pwm_q <= raw;
      en_q  <= bus.en;
    end
  end

  // Complement gated by en_q: both outputs stay low while stopped.
  assign pwm_n_q = en_q & ~pwm_q;
`endif

  assign bus.pwm          = pwm_q;
  assign bus.pwm_n        = pwm_n_q;
  assign bus.period_start = ps_q;
endmodule

// File: tb/tb_pwm_gen.sv
// Bench for pwm_gen: PRESCALE=1 and PRESCALE=4 instances against an arithmetic model.
// Builds with or without PWM_DEADTIME_EN; expectations adapt to the dead-time setting.
module tb_pwm_gen;
  localparam int D = 2;
`ifdef PWM_DEADTIME_EN
  localparam int DT = D;
`else
  localparam int DT = 0;
`endif
  localparam int H = DT + 1;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       en_r = 1'b0;
  logic [7:0] duty_r = 8'd0;

  always #5 clk = ~clk;

  pwm_if #(.WIDTH(8)) b1();
  pwm_if #(.WIDTH(8)) b4();
  assign b1.en = en_r;  assign b1.duty = duty_r;
  assign b4.en = en_r;  assign b4.duty = duty_r;

  pwm_gen #(.WIDTH(8), .PRESCALE(1), .DEADTIME(D)) dut1 (.clk(clk), .rst_n(rst_n), .bus(b1));
  pwm_gen #(.WIDTH(8), .PRESCALE(4), .DEADTIME(D)) dut4 (.clk(clk), .rst_n(rst_n), .bus(b4));

  logic pw[2], pwn[2], pst[2];
  assign pw[0] = b1.pwm;  assign pwn[0] = b1.pwm_n;  assign pst[0] = b1.period_start;
  assign pw[1] = b4.pwm;  assign pwn[1] = b4.pwm_n;  assign pst[1] = b4.period_start;

  int n_cmp = 0;
  int n_fail = 0;

  task automatic check(input string name, input longint act, input longint exp);
    n_cmp++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Reference model: ideal compare level per enabled clk from plain arithmetic.
  // hist holds the last H ideal levels (2 = stopped/reset); an output is high only
  // when its level has held for H consecutive clks.
  int         k[2] = '{0, 0};
  logic [7:0] pd[2];
  logic [1:0] hist[2][H];
  bit         exp_ps[2];

  always @(posedge clk or negedge rst_n) begin
    for (int i = 0; i < 2; i++) begin
      automatic int         p = (i == 0) ? 1 : 4;
      automatic int         kk = 0;
      automatic int         c;
      automatic logic [1:0] s = 2'd2;
      automatic logic [7:0] npd = pd[i];
      automatic bit         ps = 1'b0;
      if (!rst_n) begin
        npd = 8'd0;
      end else if (!en_r) begin
        npd = duty_r;
      end else begin
        kk = k[i] + 1;
        c  = ((kk - 1) / p) % 256;
        s  = (c < int'(pd[i])) ? 2'd1 : 2'd0;
        if (kk % (256 * p) == 0) begin
          ps  = 1'b1;
          npd = duty_r;
        end
      end
      k[i]      <= kk;
      pd[i]     <= npd;
      exp_ps[i] <= ps;
      hist[i][0] <= s;
      for (int j = 1; j < H; j++) hist[i][j] <= hist[i][j-1];
    end
  end

  bit chk_on = 1'b0;
  int err[2] = '{0, 0};
  int both_hi = 0;

  always @(negedge clk) begin
    if (chk_on) begin
      for (int i = 0; i < 2; i++) begin
        automatic bit ep = 1'b1;
        automatic bit epn = 1'b1;
        for (int j = 0; j < H; j++) begin
          if (hist[i][j] != 2'd1) ep = 1'b0;
          if (hist[i][j] != 2'd0) epn = 1'b0;
        end
        if (pw[i] !== ep || pwn[i] !== epn || pst[i] !== exp_ps[i]) err[i] <= err[i] + 1;
        if (pw[i] && pwn[i]) both_hi <= both_hi + 1;
      end
    end
  end

  task automatic sync(input int i);
    automatic int lim = (i == 0) ? 600 : 2400;
    automatic bit ok = 1'b0;
    for (int t = 0; t < lim && !ok; t++) begin
      @(negedge clk);
      if (pst[i]) ok = 1'b1;
    end
    check($sformatf("sync_period_start%0d", i), ok, 1);
  endtask

  task automatic count(input int i, input int n, output int hi, output int lo,
                       output int ps, output bit last);
    hi = 0; lo = 0; ps = 0; last = 1'b0;
    for (int t = 0; t < n; t++) begin
      @(negedge clk);
      hi += int'(pw[i]);
      lo += int'(pwn[i]);
      ps += int'(pst[i]);
      last = pst[i];
    end
  endtask

  typedef struct {
    logic [7:0] duty;
    int         hi;
    int         lo;
  } vec_t;

  vec_t tbl[6];

  initial begin
    int hi, lo, ps, hi2, lo2, ps2, lat;
    bit last, seen;

    tbl[0] = '{8'd64,  64 - DT,               192 - DT};
    tbl[1] = '{8'd0,   0,                     256};
    tbl[2] = '{8'd255, 255 - DT,              (DT == 0) ? 1 : 0};
    tbl[3] = '{8'd128, 128 - DT,              128 - DT};
    tbl[4] = '{8'd1,   (DT == 0) ? 1 : 0,     255 - DT};
    tbl[5] = '{8'd200, 200 - DT,              56 - DT};

    repeat (5) @(negedge clk);
    check("rst_pwm", b1.pwm, 0);
    check("rst_pwm_n", b1.pwm_n, 0);
    check("rst_period_start", b1.period_start, 0);
    check("rst_pwm4", b4.pwm, 0);
    rst_n = 1'b1;
    chk_on = 1'b1;
    @(negedge clk);

    // steady-state duty table, one full period each
    en_r = 1'b1;
    foreach (tbl[v]) begin
      duty_r = tbl[v].duty;
      sync(0);
      count(0, 256, hi, lo, ps, last);
      check($sformatf("tbl%0d_hi", v), hi, tbl[v].hi);
      check($sformatf("tbl%0d_lo", v), lo, tbl[v].lo);
      check($sformatf("tbl%0d_ps", v), ps * 2 + int'(last), 3);
    end

    // mid-period duty change is deferred to the next period
    duty_r = 8'd64;
    sync(0);
    count(0, 100, hi, lo, ps, last);
    duty_r = 8'd192;
    count(0, 156, hi2, lo2, ps2, last);
    check("midchg_cur_hi", hi + hi2, 64 - DT);
    check("midchg_cur_ps", ps + ps2, 1);
    count(0, 256, hi, lo, ps, last);
    check("midchg_next_hi", hi, 192 - DT);
    check("midchg_next_lo", lo, 64 - DT);

    // PRESCALE=4 instance
    duty_r = 8'd128;
    sync(1);
    count(1, 1024, hi, lo, ps, last);
    check("presc4_hi", hi, 512 - DT);
    check("presc4_lo", lo, 512 - DT);
    check("presc4_ps", ps * 2 + int'(last), 3);

    // async reset mid-period with pwm high
    duty_r = 8'd64;
    sync(0);
    count(0, 30, hi, lo, ps, last);
    check("pre_rst_pwm", pw[0], 1);
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_pwm", pw[0], 0);
    check("async_rst_pwm_n", pwn[0], 0);
    check("async_rst_ps", pst[0], 0);
    check("async_rst_pwm4", pw[1] | pwn[1], 0);
    @(negedge clk);
    rst_n = 1'b1;

    // en drop mid-period, then restart from ctr=0 with held duty
    sync(0);
    count(0, 40, hi, lo, ps, last);
    en_r = 1'b0;
    @(negedge clk);
    check("en_drop_pwm", pw[0], 0);
    check("en_drop_pwm_n", pwn[0], 0);
    repeat (3) @(negedge clk);
    en_r = 1'b1;
    lat = 0; hi = 0; seen = 1'b0;
    while (!seen && lat < 600) begin
      @(negedge clk);
      lat++;
      hi += int'(pw[0]);
      if (pst[0]) seen = 1'b1;
    end
    check("restart_ps_latency", lat, 256);
    check("restart_hi", hi, 64 - DT);

    // randomized duty/en traffic, checked cycle by cycle against the model
    for (int c = 0; c < 6000; c++) begin
      @(negedge clk);
      if ($urandom_range(0, 149) == 0) duty_r = 8'($urandom_range(0, 255));
      if ($urandom_range(0, 399) == 0) en_r = ~en_r;
      if (!en_r && $urandom_range(0, 7) == 0) en_r = 1'b1;
    end
    @(negedge clk);
    @(negedge clk);

    check("model_cycles_p1", err[0], 0);
    check("model_cycles_p4", err[1], 0);
    check("never_both_high", both_hi, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
